// File: rtl/seq_alu.sv
// seq_alu - sequential, parametrised ALU with start/done handshake.
//
// Logic, shift, add, subtract, clear and reserved opcodes finish in a single
// cycle. Multiply uses an N-cycle shift-add engine. Divide and modulo use an
// N-cycle restoring divider. Results, NZCV flags and four active-low
// 7-segment digits are registered and held until the next operation.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 request, sampled only while idle
//   a, b [N-1:0]          operands, latched on an accepted start
//   operation [3:0]       opcode, latched with the operands
//   busy                  high while an iterative op runs
//   done                  one-cycle pulse once new results are valid
//   result_lo [N-1:0]     product low half / quotient / remainder (mod)
//   result_hi [N-1:0]     product high half / remainder (div), else 0
//   carryOutF, overflowF, negativeF, zeroF   registered flags
//   display1..display4    hex digits of lo[3:0], lo[7:4], hi[3:0], hi[7:4]
module seq_alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   operation,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         carryOutF,
  output logic         overflowF,
  output logic         negativeF,
  output logic         zeroF,
  output logic [6:0]   display1,
  output logic [6:0]   display2,
  output logic [6:0]   display3,
  output logic [6:0]   display4
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_MOD = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_CLR = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    divisor_q, divisor_d;
  logic            isMod_q, isMod_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quot_q, quot_d;

  logic [N-1:0]    resLo_q, resHi_q;
  logic            carry_q, ovf_q, neg_q, zero_q, done_q;
  logic [6:0]      disp1_q, disp2_q, disp3_q, disp4_q;

  logic            wrEn, clrEn, flagEn;
  logic [N-1:0]    loN, hiN;
  logic            cN, vN, negN, zeroN;
  logic [6:0]      disp1N, disp2N, disp3N, disp4N;
  logic [N:0]      sumW, mulAdd, shifted, trial;
  logic [N-1:0]    diff;
  logic            ge;

  // Active-low hex encoding, segment order gfedcba.
  function automatic logic [6:0] segEnc(input logic [3:0] d);
    case (d)
      4'h0: segEnc = 7'b1000000;
      4'h1: segEnc = 7'b1111001;
      4'h2: segEnc = 7'b0100100;
      4'h3: segEnc = 7'b0110000;
      4'h4: segEnc = 7'b0011001;
      4'h5: segEnc = 7'b0010010;
      4'h6: segEnc = 7'b0000010;
      4'h7: segEnc = 7'b1111000;
      4'h8: segEnc = 7'b0000000;
      4'h9: segEnc = 7'b0010000;
      4'hA: segEnc = 7'b0001000;
      4'hB: segEnc = 7'b0000011;
      4'hC: segEnc = 7'b1000110;
      4'hD: segEnc = 7'b0100001;
      4'hE: segEnc = 7'b0000110;
      default: segEnc = 7'b0001110;
    endcase
  endfunction

  // Next-state, iteration datapath and the values written to the output
  // registers whenever wrEn is raised (single-cycle op or last iteration).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    divisor_d = divisor_q;
    isMod_d   = isMod_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    wrEn      = 1'b0;
    clrEn     = 1'b0;
    flagEn    = 1'b1;
    loN       = '0;
    hiN       = '0;
    cN        = 1'b0;
    vN        = 1'b0;

    sumW = {1'b0, a} + {1'b0, b};
    diff = a - b;

    // Shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole product (and the multiplier) right.
    mulAdd = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and remainder = a.
    shifted = {rem_q, quot_q[N-1]};
    trial   = shifted - {1'b0, divisor_q};
    ge      = (shifted >= {1'b0, divisor_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_AND: begin wrEn = 1'b1; loN = a & b; end
            OP_OR:  begin wrEn = 1'b1; loN = a | b; end
            OP_XOR: begin wrEn = 1'b1; loN = a ^ b; end
            OP_SHL: begin
              wrEn = 1'b1;
              loN  = (32'(b) >= N) ? '0 : (a << b);
            end
            OP_SHR: begin
              wrEn = 1'b1;
              loN  = (32'(b) >= N) ? '0 : (a >> b);
            end
            OP_ADD: begin
              wrEn = 1'b1;
              loN  = sumW[N-1:0];
              cN   = sumW[N];
              vN   = (a[N-1] == b[N-1]) && (sumW[N-1] != a[N-1]);
            end
            OP_SUB: begin
              wrEn = 1'b1;
              loN  = diff;
              cN   = (a < b);
              vN   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_MUL: begin
              mcand_d = a;
              prod_d  = {{N{1'b0}}, b};
              cnt_d   = '0;
              state_d = MUL;
            end
            OP_DIV, OP_MOD: begin
              divisor_d = b;
              quot_d    = a;
              rem_d     = '0;
              isMod_d   = (operation == OP_MOD);
              cnt_d     = '0;
              state_d   = DIV;
            end
            OP_CLR: begin
              wrEn   = 1'b1;
              clrEn  = 1'b1;
              flagEn = 1'b0;
            end
            default: begin
              wrEn   = 1'b1;
              flagEn = 1'b0;
            end
          endcase
        end
      end

      MUL: begin
        prod_d = {mulAdd, prod_q[N-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          wrEn    = 1'b1;
          loN     = prod_d[N-1:0];
          hiN     = prod_d[2*N-1:N];
          vN      = |prod_d[2*N-1:N];
          state_d = IDLE;
        end
      end

      DIV: begin
        rem_d  = ge ? N'(trial) : N'(shifted);
        quot_d = {quot_q[N-2:0], ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          wrEn    = 1'b1;
          loN     = isMod_q ? rem_d : quot_d;
          hiN     = isMod_q ? '0 : rem_d;
          vN      = (divisor_q == '0);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    negN  = flagEn & loN[N-1];
    zeroN = flagEn & ({hiN, loN} == '0);

    // Upper nibbles only exist once N exceeds 4; otherwise they stay blank.
    disp1N = clrEn ? BLANK : segEnc(4'(loN));
    disp2N = (clrEn || N <= 4) ? BLANK : segEnc(4'(loN >> 4));
    disp3N = clrEn ? BLANK : segEnc(4'(hiN));
    disp4N = (clrEn || N <= 4) ? BLANK : segEnc(4'(hiN >> 4));
  end

  // State, engine registers and held outputs; done is wrEn delayed a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      divisor_q <= '0;
      isMod_q   <= 1'b0;
      prod_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      resLo_q   <= '0;
      resHi_q   <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      disp1_q   <= BLANK;
      disp2_q   <= BLANK;
      disp3_q   <= BLANK;
      disp4_q   <= BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      divisor_q <= divisor_d;
      isMod_q   <= isMod_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      done_q    <= wrEn;
      if (wrEn) begin
        resLo_q <= loN;
        resHi_q <= hiN;
        carry_q <= cN;
        ovf_q   <= vN;
        neg_q   <= negN;
        zero_q  <= zeroN;
        disp1_q <= disp1N;
        disp2_q <= disp2N;
        disp3_q <= disp3N;
        disp4_q <= disp4N;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result_lo = resLo_q;
  assign result_hi = resHi_q;
  assign carryOutF = carry_q;
  assign overflowF = ovf_q;
  assign negativeF = neg_q;
  assign zeroF     = zero_q;
  assign display1  = disp1_q;
  assign display2  = disp2_q;
  assign display3  = disp3_q;
  assign display4  = disp4_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu - directed testbench for seq_alu.
//
// Two instances run side by side: dut4 (N=4) and dut8 (N=8). They share the
// clock, reset, opcode and operand buses (dut4 sees the low nibble of each
// operand) but have separate start strobes. Expected values are hand-computed.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] operation;
  logic [7:0] aIn, bIn;

  logic       busy4, done4, c4, v4, n4, z4;
  logic [3:0] lo4, hi4;
  logic [6:0] d41, d42, d43, d44;

  logic       busy8, done8, c8, v8, n8, z8;
  logic [7:0] lo8, hi8;
  logic [6:0] d81, d82, d83, d84;

  int vecCount  = 0;
  int missCount = 0;
  int lat;
  int seen;

  localparam logic [3:0] ADD = 4'b0110, SUB = 4'b0111, MUL = 4'b1000;
  localparam logic [3:0] DIV = 4'b1001, MOD = 4'b0101, SHL = 4'b0011;
  localparam logic [3:0] SHR = 4'b0100, CLR = 4'b1111, RSV = 4'b1010;
  localparam logic [6:0] BLANK = 7'b1111111;

  seq_alu #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(aIn[3:0]), .b(bIn[3:0]),
    .operation(operation), .busy(busy4), .done(done4),
    .result_lo(lo4), .result_hi(hi4),
    .carryOutF(c4), .overflowF(v4), .negativeF(n4), .zeroF(z4),
    .display1(d41), .display2(d42), .display3(d43), .display4(d44)
  );

  seq_alu #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(aIn), .b(bIn),
    .operation(operation), .busy(busy8), .done(done8),
    .result_lo(lo8), .result_hi(hi8),
    .carryOutF(c8), .overflowF(v8), .negativeF(n8), .zeroF(z8),
    .display1(d81), .display2(d82), .display3(d83), .display4(d84)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and pulse start for exactly one rising edge. Returns
  // #1 after the edge that sampled start.
  task automatic applyStimulus(input bit wide, input logic [3:0] op,
                               input logic [7:0] av, input logic [7:0] bv);
    operation = op;
    aIn       = av;
    bIn       = bv;
    if (wide) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Count further edges until done is seen, with a bounded budget.
  task automatic waitForDone(input bit wide, output int edges);
    edges = 0;
    while (((wide ? done8 : done4) == 1'b0) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 40) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL done timeout: got no done, expected done within 40 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    operation = 4'b0; aIn = 8'h0; bIn = 8'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    checkOutput("rst lo4", lo4, 0);
    checkOutput("rst busy4", busy4, 0);
    checkOutput("rst done4", done4, 0);
    checkOutput("rst zero4", z4, 0);
    checkOutput("rst disp1_4", d41, BLANK);
    checkOutput("rst disp4_8", d84, BLANK);
    rst = 1'b0;

    // N=4 add 7+9 wraps to 0 with carry
    applyStimulus(0, ADD, 8'h07, 8'h09);
    waitForDone(0, lat);
    checkOutput("add4 lat", lat, 0);
    checkOutput("add4 lo", lo4, 4'b0000);
    checkOutput("add4 c", c4, 1);
    checkOutput("add4 z", z4, 1);
    checkOutput("add4 v", v4, 0);
    checkOutput("add4 disp1", d41, 7'b1000000);
    checkOutput("add4 disp2", d42, BLANK);
    @(posedge clk); #1;
    checkOutput("add4 done pulse", done4, 0);

    // N=4 subtract with borrow, then signed overflow
    applyStimulus(0, SUB, 8'h03, 8'h05);
    waitForDone(0, lat);
    checkOutput("sub4 lo", lo4, 4'b1110);
    checkOutput("sub4 c", c4, 1);
    checkOutput("sub4 n", n4, 1);
    checkOutput("sub4 v", v4, 0);
    applyStimulus(0, SUB, 8'h07, 8'h08);
    waitForDone(0, lat);
    checkOutput("sub4b lo", lo4, 4'b1111);
    checkOutput("sub4b v", v4, 1);

    // N=4 multiply 15*15 with an ignored start pulse mid-run
    applyStimulus(0, MUL, 8'h0F, 8'h0F);
    checkOutput("mul4 busy", busy4, 1);
    @(posedge clk); #1;
    operation = ADD; aIn = 8'h01; bIn = 8'h01; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    checkOutput("mul4 busy mid", busy4, 1);
    checkOutput("mul4 no early done", done4, 0);
    waitForDone(0, lat);
    checkOutput("mul4 lat", lat + 2, 4);
    checkOutput("mul4 hi", hi4, 4'b1110);
    checkOutput("mul4 lo", lo4, 4'b0001);
    checkOutput("mul4 v", v4, 1);
    checkOutput("mul4 c", c4, 0);
    checkOutput("mul4 busy end", busy4, 0);
    checkOutput("mul4 disp1", d41, 7'b1111001);
    checkOutput("mul4 disp3", d43, 7'b0000110);
    @(posedge clk); #1;
    checkOutput("mul4 done pulse", done4, 0);
    @(posedge clk); #1;
    checkOutput("mul4 start ignored", done4, 0);

    // N=4 divide, divide by zero, modulo
    applyStimulus(0, DIV, 8'h0D, 8'h04);
    waitForDone(0, lat);
    checkOutput("div4 lat", lat, 4);
    checkOutput("div4 lo", lo4, 4'b0011);
    checkOutput("div4 hi", hi4, 4'b0001);
    checkOutput("div4 v", v4, 0);
    applyStimulus(0, DIV, 8'h0D, 8'h00);
    waitForDone(0, lat);
    checkOutput("div0 lo", lo4, 4'b1111);
    checkOutput("div0 hi", hi4, 4'b1101);
    checkOutput("div0 v", v4, 1);
    checkOutput("div0 n", n4, 1);
    applyStimulus(0, MOD, 8'h0D, 8'h04);
    waitForDone(0, lat);
    checkOutput("mod4 lo", lo4, 4'b0001);
    checkOutput("mod4 hi", hi4, 4'b0000);
    checkOutput("mod4 v", v4, 0);

    // N=4 clear after modulo, then a reserved opcode
    applyStimulus(0, CLR, 8'h05, 8'h03);
    waitForDone(0, lat);
    checkOutput("clr4 lat", lat, 0);
    checkOutput("clr4 lo", lo4, 0);
    checkOutput("clr4 disp1", d41, BLANK);
    checkOutput("clr4 disp3", d43, BLANK);
    applyStimulus(0, RSV, 8'h03, 8'h03);
    waitForDone(0, lat);
    checkOutput("rsv4 lat", lat, 0);
    checkOutput("rsv4 lo", lo4, 0);
    checkOutput("rsv4 z", z4, 0);
    checkOutput("rsv4 disp1", d41, 7'b1000000);

    // N=8 shifts
    applyStimulus(1, SHL, 8'h81, 8'h01);
    waitForDone(1, lat);
    checkOutput("shl8 lo", lo8, 8'h02);
    checkOutput("shl8 disp1", d81, 7'b0100100);
    checkOutput("shl8 disp2", d82, 7'b1000000);
    checkOutput("shl8 n", n8, 0);
    applyStimulus(1, SHR, 8'h81, 8'h08);
    waitForDone(1, lat);
    checkOutput("shr8 lo", lo8, 8'h00);
    checkOutput("shr8 z", z8, 1);

    // N=8 reset during the third multiply iteration
    applyStimulus(1, MUL, 8'h0F, 8'h0D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mul8 busy pre-rst", busy8, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst8 busy", busy8, 0);
    checkOutput("rst8 done", done8, 0);
    checkOutput("rst8 z", z8, 0);
    checkOutput("rst8 lo", lo8, 0);
    checkOutput("rst8 disp1", d81, BLANK);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    checkOutput("rst8 no done", seen, 0);

    applyStimulus(1, ADD, 8'h12, 8'h34);
    waitForDone(1, lat);
    checkOutput("add8 lat", lat, 0);
    checkOutput("add8 lo", lo8, 8'h46);
    checkOutput("add8 disp1", d81, 7'b0000010);
    checkOutput("add8 disp2", d82, 7'b0011001);

    applyStimulus(1, CLR, 8'h00, 8'h00);
    waitForDone(1, lat);
    checkOutput("clr8 lat", lat, 0);
    checkOutput("clr8 lo", lo8, 0);
    checkOutput("clr8 disp2", d82, BLANK);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential, parametrised successor to the lab-3 combinational ALU. It latches operands on a start/done handshake. Logic, shift, add and subtract complete in one cycle. Multiply, divide and modulo run as N-cycle iterative engines (shift-add and restoring division). Results, NZCV flags and four active-low 7-segment digit encodings are registered and held until the next operation, so the block can sit between the board switch/button front end and the HEX displays, or feed a later datapath.

## Interface
- N, default 4: operand width in bits; legal values 4..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- a  in  N  operand A.
- b  in  N  operand B.
- operation  in  4  opcode, latched with the operands.
- busy  out  N/A  1 bit; high while an iterative op runs.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- result_lo  out  N  primary result: product low half or quotient.
- result_hi  out  N  product high half or remainder; 0 for other ops.
- carryOutF, overflowF, negativeF, zeroF  out  1 each  registered flags.
- display1..display4  out  7 each  active-low segments for result_lo[3:0], result_lo[7:4], result_hi[3:0] and result_hi[7:4]. For N<8, any upper nibble that does not exist is blanked (1111111).
- Reset value of every output is 0, except display1..display4, which reset to 7'b1111111 (blank).

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 XOR
  - 0011 shift left a by b
  - 0100 logical shift right a by b
  - 0101 a mod b
  - 0110 a+b
  - 0111 a−b
  - 1000 a×b, unsigned, 2N-bit result
  - 1001 a÷b, unsigned
  - 1111 clear
  - 1010–1110 reserved: result 0, flags 0, done still pulses.
- FSM states: IDLE, MUL, DIV. Only IDLE accepts start.
- IDLE + start with a single-cycle opcode (0000–0100, 0110, 0111, 1111, reserved): compute from a and b and write all outputs on the same edge. done pulses in the next cycle. busy stays 0.
- IDLE + start with 1000: latch operands, clear the accumulator, go to MUL with counter = 0, busy=1.
- IDLE + start with 1001 or 0101: go to DIV, same latching.
- MUL/DIV: one iteration per clock. After N iterations, write results and flags, return to IDLE, busy=0, and pulse done.
- start while busy is ignored, with no queueing. Operands and opcode changing while busy have no effect.
- Shift amount ≥ N gives 0.
- Add:
  - carryOutF = carry out of bit N−1.
  - overflowF = signed overflow.
- Subtract:
  - carryOutF = borrow (a<b, unsigned).
  - overflowF = signed overflow.
- Multiply: overflowF = (result_hi≠0). carryOutF=0.
- Divide and modulo:
  - Divide writes the quotient to result_lo and the remainder to result_hi.
  - Modulo writes the remainder to result_lo and sets result_hi=0.
- Divide by zero:
  - Divide gives quotient all-ones and remainder = a.
  - Modulo gives result_lo = a.
  - Both set overflowF=1.
- Logic and shift ops: carryOutF=0, overflowF=0.
- negativeF = MSB of result_lo, for every op except clear and reserved.
- zeroF = ({result_hi,result_lo} == 0).
- Clear (1111): all results, flags and displays return to their reset values. done pulses.
- Displays are registered together with the results and use the hex encoding 0→1000000 … F→0001110. A zero digit shows 1000000, never blank.

## Timing
- Single-cycle ops: start sampled at edge k. Outputs are updated at edge k, and done is high in the cycle after edge k only.
- Iterative ops: start sampled at edge k. Iterations occur at edges k+1..k+N. Results update and busy falls at edge k+N. done is high in the cycle after edge k+N.
- The earliest accepted back-to-back start is the cycle in which done is high.
- Outputs hold their values between done pulses.
- rst asserted at any time, including mid-iteration: all state and outputs return to reset values immediately, FSM goes to IDLE, and no done is produced for the aborted op.
- Release of rst is synchronous to the next clk edge. start can be accepted at the first edge after release.

## Test plan
- N=4, add a=0111 b=1001 → result_lo=0000, carryOutF=1, zeroF=1, overflowF=0, done exactly one cycle after start.
- N=4, sub a=0011 b=0101 → result_lo=1110, carryOutF=1, negativeF=1, overflowF=0. Then sub a=0111 b=1000 → overflowF=1.
- N=4, mul a=1111 b=1111 → result_hi=1110, result_lo=0001, overflowF=1. done 4 cycles after start. A start pulsed mid-run is ignored.
- N=4, div a=1101 b=0100 → result_lo=0011, result_hi=0001. Then div b=0 → result_lo=1111, result_hi=1101, overflowF=1. Then mod a=1101 b=0100 → result_lo=0001.
- N=8, shift left a=0x81 b=1 → 0x02, display1=0100100, display2=1000000. Then shift right with b=8 → 0, zeroF=1.
- N=8, assert rst at iteration 3 of a multiply → busy=0, all outputs at reset values, no done. A new add started after release completes normally. Opcode 1111 after any op → all outputs at reset values, done pulses.
